// File: rtl/delay_tank_port.sv
// delay_tank_port: access port at the two ends of one recirculating serial
// delay-line tank. Tracks the slot on tank_out, recirculates every bit, and
// serves one single-word read or write on the addressed slot's next pass.
module delay_tank_port #(
  parameter int unsigned WORD_BITS = 18,
  parameter int unsigned WORDS     = 32,
  parameter int unsigned ADDR_W    = 5,
  localparam int unsigned BIT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tank_out,
  output logic                 tank_in,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 ack,
  output logic [WORD_BITS-1:0] rdata,
  output logic [ADDR_W-1:0]    word_pos,
  output logic [BIT_W-1:0]     bit_pos
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_BITS - 1);
  localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WORDS - 1);

  logic [1:0]           state;
  logic [ADDR_W-1:0]    addr_l;
  logic                 we_l;
  logic [WORD_BITS-1:0] wdata_l;

  logic slot_match;
  logic active;
  logic last_bit;

  // Slot decode: the access window opens on bit 0 of the latched word.
  always_comb begin
    last_bit   = (bit_pos == BIT_LAST);
    slot_match = (word_pos == addr_l) && (bit_pos == '0);
    active     = ((state == S_WAIT) && slot_match) || (state == S_XFER);
  end

  // Free-running bit/word slot counters aligned with tank_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_pos  <= '0;
      word_pos <= '0;
    end else begin
      bit_pos <= last_bit ? '0 : bit_pos + BIT_W'(1);
      if (last_bit) begin
        word_pos <= (word_pos == WORD_LAST) ? '0 : word_pos + ADDR_W'(1);
      end
    end
  end

  // Request sequencing: latch in IDLE, wait for slot, transfer, acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr_l  <= '0;
      we_l    <= 1'b0;
      wdata_l <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_l  <= addr;
            we_l    <= we;
            wdata_l <= wdata;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Bit 0 is handled in the matching WAIT cycle, so a one-bit word
          // has nothing left for XFER.
          if (slot_match) begin
            state <= (WORD_BITS == 1) ? S_DONE : S_XFER;
          end
        end
        S_XFER: begin
          if (last_bit) begin
            state <= S_DONE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Serial datapath: overwrite or recirculate into the tank, shift reads in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tank_in <= 1'b0;
      rdata   <= '0;
    end else begin
      tank_in <= (active && we_l) ? wdata_l[bit_pos] : tank_out;
      if (active && !we_l) begin
        rdata <= WORD_BITS'({tank_out, rdata} >> 1);
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign ack  = (state == S_DONE);

endmodule

// File: tb/tb_delay_tank_port.sv
// Bench for delay_tank_port: a 575-cycle delay line closes the loop, a word
// array models tank contents, and a scoreboard checks every acknowledge.
module tb_delay_tank_port;

  localparam int WB   = 18;
  localparam int NW   = 32;
  localparam int AW   = 5;
  localparam int BW   = 5;
  localparam int LINE = NW * WB - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tank_out;
  logic          tank_in;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [WB-1:0] wdata = '0;
  logic          busy;
  logic          ack;
  logic [WB-1:0] rdata;
  logic [AW-1:0] word_pos;
  logic [BW-1:0] bit_pos;

  always #5 clk = ~clk;

  delay_tank_port #(.WORD_BITS(WB), .WORDS(NW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .tank_out(tank_out), .tank_in(tank_in),
    .req(req), .we(we), .addr(addr), .wdata(wdata), .busy(busy), .ack(ack),
    .rdata(rdata), .word_pos(word_pos), .bit_pos(bit_pos)
  );

  // External delay line: circular buffer, value in at one negedge returns
  // LINE negedges later.
  logic line [LINE];
  int   lp = 0;
  initial begin
    for (int i = 0; i < LINE; i++) line[i] = 1'($urandom);
    tank_out = 1'($urandom);
  end
  always @(negedge clk) begin
    tank_out = line[lp];
    line[lp] = tank_in;
    lp = (lp + 1) % LINE;
  end

  // Slot reference: which word/bit should be on tank_out.
  int mw = 0, mb = 0;
  bit started = 1'b0, in_rst = 1'b0;
  always @(posedge clk) begin
    in_rst = !rst_n;
    if (!rst_n) begin
      started = 1'b1; mw = 0; mb = 0;
    end else begin
      mb++;
      if (mb == WB) begin mb = 0; mw = (mw + 1) % NW; end
    end
  end

  typedef struct { bit is_rd; logic [WB-1:0] exp; } exp_t;
  exp_t sbq[$];
  logic [WB-1:0] mem [NW];
  logic [WB-1:0] last_rd = '0;
  int checks = 0, passes = 0, ack_count = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  // Monitor: slot counters every cycle, reset outputs, scoreboard on ack.
  always @(negedge clk) begin
    if (started) begin
      chk("word_pos", 32'(word_pos), 32'(mw));
      chk("bit_pos", 32'(bit_pos), 32'(mb));
      if (in_rst) begin
        chk("rst_tank_in", 32'(tank_in), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
      end
      if (ack) begin
        ack_count++;
        chk("busy_at_ack", 32'(busy), 32'd1);
        if (sbq.size() == 0) begin
          chk("spurious_ack", 32'(ack), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.is_rd) chk("rdata", 32'(rdata), 32'(e.exp));
          else         chk("rdata_hold", 32'(rdata), 32'(e.exp));
        end
      end
    end
  end

  task automatic do_op(input bit w, input int a, input logic [WB-1:0] d, input bit intrude);
    int cyc, n;
    n = 0;
    @(negedge clk);
    while (busy && n < 1000) begin @(negedge clk); n++; end
    req = 1'b1; we = w; addr = AW'(a); wdata = d;
    if (w) begin
      mem[a] = d;
      sbq.push_back('{is_rd: 1'b0, exp: last_rd});
    end else begin
      sbq.push_back('{is_rd: 1'b1, exp: mem[a]});
      last_rd = mem[a];
    end
    cyc = 1;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); addr = AW'($urandom); wdata = WB'($urandom);
    forever begin
      @(negedge clk);
      cyc++;
      if (intrude && cyc <= 4) begin
        req = 1'b1; we = 1'b1; addr = AW'(5); wdata = WB'($urandom) | 18'h1;
      end else if (intrude) begin
        req = 1'b0;
      end
      if (ack) break;
      if (cyc > 700) begin chk("ack_timeout", 32'(ack), 32'd1); break; end
    end
    chk("latency_range", 32'(cyc >= 20 && cyc <= 595), 32'd1);
  endtask

  task automatic long_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (NW * WB) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    last_rd = '0;
    sbq.delete();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    // Power-up: long reset clears the tank.
    repeat (NW * WB) @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 0, '0, 1'b0);
    do_op(1'b0, 17, '0, 1'b0);
    do_op(1'b0, 31, '0, 1'b0);
    // Basic write/read and neighbours.
    do_op(1'b1, 3, 18'h2A5A5, 1'b0);
    do_op(1'b0, 3, '0, 1'b0);
    do_op(1'b0, 2, '0, 1'b0);
    do_op(1'b0, 4, '0, 1'b0);
    // Wrap-around slot.
    do_op(1'b1, 31, 18'h3FFFF, 1'b0);
    do_op(1'b0, 0, '0, 1'b0);
    do_op(1'b0, 31, '0, 1'b0);
    // Request while busy is ignored.
    do_op(1'b0, 10, '0, 1'b1);
    do_op(1'b0, 5, '0, 1'b0);
    // Two revolutions of recirculation.
    do_op(1'b1, 12, 18'h00001, 1'b0);
    repeat (2 * NW * WB) @(negedge clk);
    do_op(1'b0, 12, '0, 1'b0);
    // Randomized traffic.
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      do_op(1'($urandom), int'($urandom_range(0, NW - 1)), WB'($urandom), 1'b0);
    end
    for (int k = 0; k < NW; k += 7) do_op(1'b0, k, '0, 1'b0);
    // Reset in the middle of a write transfer to slot 7.
    @(negedge clk);
    n = 0;
    while ((busy || mw != 20) && n < 2000) begin @(negedge clk); n++; end
    req = 1'b1; we = 1'b1; addr = AW'(7); wdata = 18'h15555;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    n = 0;
    while (!(mw == 7 && mb == 8) && n < 2000) begin @(negedge clk); n++; end
    chk("busy_mid_xfer", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("busy_after_rst", 32'(busy), 32'd0);
    chk("ack_after_rst", 32'(ack), 32'd0);
    chk("bit_pos_restart", 32'(bit_pos), 32'd0);
    chk("word_pos_restart", 32'(word_pos), 32'd0);
    a0 = ack_count;
    repeat (700) @(negedge clk);
    chk("no_ack_after_rst", 32'(ack_count - a0), 32'd0);
    // Clear the tank again and confirm.
    long_reset();
    do_op(1'b0, 7, '0, 1'b0);
    do_op(1'b1, 7, 18'h0ABCD, 1'b0);
    do_op(1'b0, 7, '0, 1'b0);
    do_op(1'b0, 8, '0, 1'b0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/delay_tank_port.md
Name: delay_tank_port

Overview:
- Access port at the two ends of one recirculating serial delay-line tank (EDSAC-style mercury tank).
- Takes the serial bit stream leaving the delay line and re-drives it into the delay line input, either unchanged or overwritten.
- Tracks the bit/word slot currently emerging from the tank.
- Serves single-word read or write requests from the order/store logic, each completing on the slot's next pass.

Parameters:
WORD_BITS, 18, bits per word slot, transmitted LSB first
WORDS, 32, word slots per tank revolution
ADDR_W, 5, word address width, equal to clog2(WORDS)

Ports:
clk  input  1  system clock; one bit slot per cycle
rst_n  input  1  synchronous active-low reset
tank_out  input  1  serial bit emerging from the delay line output
tank_in  output  1  serial bit driven into the delay line input; registered
req  input  1  access request, sampled only while idle
we  input  1  1 = write, 0 = read; sampled with req
addr  input  ADDR_W  target word slot; sampled with req
wdata  input  WORD_BITS  write word; sampled with req
busy  output  1  request accepted and not yet acknowledged
ack  output  1  one-cycle pulse when the access completes
rdata  output  WORD_BITS  word read; valid while ack=1 after a read, held until the next read completes
word_pos  output  ADDR_W  word slot currently on tank_out
bit_pos  output  clog2(WORD_BITS)  bit index currently on tank_out

Behaviour:
- Loop contract: the external delay line is WORDS*WORD_BITS-1 cycles long, so a value registered into tank_in during slot (w,b) returns on tank_out at slot (w,b) one revolution later.
- Slot counters:
  - bit_pos increments every cycle and wraps WORD_BITS-1 -> 0.
  - word_pos increments when bit_pos wraps, and wraps WORDS-1 -> 0.
  - Both counters free-run regardless of requests.
- Reset (rst_n=0 at an edge):
  - bit_pos=0, word_pos=0, tank_in=0, busy=0, ack=0, rdata=0, state IDLE.
  - The in-flight request is discarded.
  - While reset is held, tank_in stays 0, so holding reset for WORDS*WORD_BITS cycles zeroes the tank.
- States IDLE, WAIT, XFER, DONE:
  - IDLE: when req=1, latch addr/we/wdata -> WAIT.
  - WAIT: hold. Define active = (WAIT and word_pos==latched addr and bit_pos==0) or XFER.
    - Transition to XFER on the cycle where the slot match occurs.
    - If WORD_BITS==1, go straight to DONE.
    - A request whose address matches the very next cycle still waits for that match; it is never served in the request cycle itself.
  - XFER: on the cycle with bit_pos==WORD_BITS-1 -> DONE.
  - DONE: ack=1 for this single cycle -> IDLE. A new req may be sampled in the first IDLE cycle after DONE.
- busy=1 in WAIT, XFER and DONE.
- req is ignored when not in IDLE; no queuing.
- Datapath, per cycle:
  - tank_in next value = wdata_latched[bit_pos] if active and write; otherwise tank_out (recirculate).
  - Read while active: the rdata shift register takes tank_out into the MSB and shifts right. After WORD_BITS shifts the LSB-first stream is therefore in order, bit 0 at rdata[0].
  - Writes leave rdata unchanged.
- Latency from the req edge to ack: minimum WORD_BITS+2 cycles, maximum WORDS*WORD_BITS+WORD_BITS+1 cycles.
- Wrap-around: word slot WORDS-1 behaves identically to the others; its last bit is followed immediately by slot (0,0).
- Only the addressed word is altered; all other slots recirculate bit-exact indefinitely.

Test Plan:
- Bench model: the delay line is a shift register of 575 cycles (defaults) fed by tank_in and driving tank_out.
1. Hold rst_n=0 for 576 cycles, then release -> tank_in=0, busy=0, ack=0 during reset; every later read of any address returns 0.
2. Write addr=3, wdata=18'h2A5A5 -> ack after between 20 and 595 cycles; then read addr=3 -> rdata=18'h2A5A5 with ack=1; reads of addr=2 and addr=4 return 0.
3. Write addr=31, wdata=18'h3FFFF, then read addr=0 -> addr 0 returns 0 (no bleed across the wrap); read addr=31 -> 18'h3FFFF.
4. Issue req for addr=5 while busy serving addr=10 -> only addr=10 is served, one ack pulse; addr=5 is untouched.
5. Assert rst_n=0 for one cycle mid-XFER of a write to addr=7 -> busy=0 and ack=0 next cycle, no ack ever for that request; bit_pos and word_pos restart at 0.
6. Write addr=12 data 18'h00001, wait 1152 cycles, read -> 18'h00001. Checks stable recirculation across two revolutions and the LSB position.
